// File: rtl/grid_cell_renderer.sv
// Streams the filled squares of one or all board cells to the VGA adapter,
// one registered pixel per clock, with colours taken from a grid snapshot.
module grid_cell_renderer #(
    parameter int unsigned GRID_N     = 3,
    parameter int unsigned CELL_SIZE  = 26,
    parameter int unsigned CELL_PITCH = 30,
    parameter int unsigned ORIGIN_X   = 37,
    parameter int unsigned ORIGIN_Y   = 7,
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 7,
    parameter int unsigned IDX_W      = 2
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [2*GRID_N*GRID_N-1:0]   grid,
    input  logic                         start,
    input  logic                         single,
    input  logic [IDX_W-1:0]             sel_row,
    input  logic [IDX_W-1:0]             sel_col,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [2:0]                   colour,
    output logic                         plot,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned GRID_W = 2*GRID_N*GRID_N;
    localparam int unsigned PIX_W  = $clog2(CELL_SIZE+1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t              state, state_nxt;
    logic [GRID_W-1:0]   snap;
    logic                single_r;
    logic [IDX_W-1:0]    row, col, row_nxt, col_nxt;
    logic [PIX_W-1:0]    px, py, px_nxt, py_nxt;
    logic [X_W-1:0]      x_nxt;
    logic [Y_W-1:0]      y_nxt;
    logic [2:0]          colour_nxt;
    logic                plot_nxt;
    logic [GRID_W-1:0]   src;
    logic [31:0]         cell_idx;
    logic [1:0]          code;
    logic                sel_oob, px_last, py_last, cell_last;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            snap     <= '0;
            single_r <= 1'b0;
            row      <= '0;
            col      <= '0;
            px       <= '0;
            py       <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
        end else begin
            state  <= state_nxt;
            row    <= row_nxt;
            col    <= col_nxt;
            px     <= px_nxt;
            py     <= py_nxt;
            x      <= x_nxt;
            y      <= y_nxt;
            colour <= colour_nxt;
            plot   <= plot_nxt;
            if (state == IDLE && start) begin
                snap     <= grid;
                single_r <= single;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        col_nxt    = col;
        px_nxt     = px;
        py_nxt     = py;
        plot_nxt   = 1'b0;
        x_nxt      = x;
        y_nxt      = y;
        colour_nxt = colour;

        sel_oob   = (32'(sel_row) >= GRID_N) || (32'(sel_col) >= GRID_N);
        px_last   = (32'(px) == CELL_SIZE - 1);
        py_last   = (32'(py) == CELL_SIZE - 1);
        cell_last = single_r || ((32'(row) == GRID_N - 1) && (32'(col) == GRID_N - 1));

        case (state)
            IDLE: begin
                if (start) begin
                    if (single && sel_oob) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DRAW;
                        row_nxt   = single ? sel_row : '0;
                        col_nxt   = single ? sel_col : '0;
                        px_nxt    = '0;
                        py_nxt    = '0;
                        plot_nxt  = 1'b1;
                    end
                end
            end
            DRAW: begin
                plot_nxt = 1'b1;
                if (!px_last) begin
                    px_nxt = px + 1'b1;
                end else begin
                    px_nxt = '0;
                    if (!py_last) begin
                        py_nxt = py + 1'b1;
                    end else begin
                        py_nxt = '0;
                        if (cell_last) begin
                            state_nxt = DONE;
                            plot_nxt  = 1'b0;
                        end else if (32'(col) == GRID_N - 1) begin
                            col_nxt = '0;
                            row_nxt = row + 1'b1;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The first pixel is produced while the snapshot is being latched, so read the live grid in IDLE.
        src      = (state == IDLE) ? grid : snap;
        cell_idx = 32'(row_nxt) * GRID_N + 32'(col_nxt);
        code     = 2'(src >> (2 * cell_idx));

        if (plot_nxt) begin
            x_nxt = X_W'(ORIGIN_X + 32'(col_nxt) * CELL_PITCH + 32'(px_nxt));
            y_nxt = Y_W'(ORIGIN_Y + 32'(row_nxt) * CELL_PITCH + 32'(py_nxt));
            case (code)
                2'd0:    colour_nxt = 3'b111;
                2'd1:    colour_nxt = 3'b011;
                2'd2:    colour_nxt = 3'b101;
                default: colour_nxt = 3'b000;
            endcase
        end
    end

    assign busy = (state == DRAW);
    assign done = (state == DONE);

endmodule

// File: tb/tb_grid_cell_renderer.sv
// Randomised bench for grid_cell_renderer: a pixel-list model built from the
// board rules is compared against the DUT outputs on every falling edge.
module tb_grid_cell_renderer;

    localparam int N  = 3;
    localparam int CS = 26;
    localparam int P  = 30;
    localparam int OX = 37;
    localparam int OY = 7;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [17:0] grid = '0;
    logic        start = 1'b0;
    logic        single = 1'b0;
    logic [1:0]  sel_row = '0;
    logic [1:0]  sel_col = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    grid_cell_renderer #(
        .GRID_N(N), .CELL_SIZE(CS), .CELL_PITCH(P), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .X_W(8), .Y_W(7), .IDX_W(2)
    ) dut (
        .clock(clock), .resetn(resetn), .grid(grid), .start(start), .single(single),
        .sel_row(sel_row), .sel_col(sel_col), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    pix_t        exp_q[$];
    pix_t        acc_q[$];
    pix_t        last_pix = '0;
    pix_t        cur;
    int          m_phase = 0;     // 0 idle, 1 drawing, 2 done pulse (current cycle)
    bit          done_pending = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          run_pix = 0;
    int          first_x = -1;
    int          first_y = -1;
    logic [20:0] act_v, exp_v;

    function automatic logic [2:0] code_col(logic [1:0] k);
        case (k)
            2'd0:    return 3'b111;
            2'd1:    return 3'b011;
            2'd2:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Expected pixel list for one accepted request, from the board geometry.
    task automatic model_accept(bit s, int r, int c);
        pix_t p;
        if (s && (r >= N || c >= N)) begin
            done_pending = 1'b1;
        end else begin
            for (int cr = 0; cr < N; cr++)
                for (int cc = 0; cc < N; cc++)
                    if (!s || (cr == r && cc == c))
                        for (int py = 0; py < CS; py++)
                            for (int px = 0; px < CS; px++) begin
                                p.x = 8'(OX + cc*P + px);
                                p.y = 7'(OY + cr*P + py);
                                p.c = code_col(grid[2*(cr*N+cc) +: 2]);
                                exp_q.push_back(p);
                            end
        end
        acc_q = exp_q;
    endtask

    always @(negedge clock) begin
        act_v = {plot, busy, done, x, y, colour};
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            exp_v = {3'b110, cur};
            last_pix = cur;
            m_phase = 1;
            if (run_pix == 0) begin
                first_x = int'(x);
                first_y = int'(y);
            end
            run_pix++;
            if (exp_q.size() == 0) done_pending = 1'b1;
        end else if (done_pending) begin
            exp_v = {3'b001, last_pix};
            done_pending = 1'b0;
            m_phase = 2;
        end else begin
            exp_v = {3'b000, last_pix};
            m_phase = 0;
        end
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL pixel_stream t=%0t {plot,busy,done,x,y,col} act=%h exp=%h",
                     $time, act_v, exp_v);
        end
    end

    task automatic check_val(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, expv);
        end
    endtask

    task automatic pulse_start(bit s, logic [1:0] r, logic [1:0] c);
        @(negedge clock); #2;
        single = s; sel_row = r; sel_col = c; start = 1'b1;
        if (m_phase == 0 && resetn) begin
            run_pix = 0;
            model_accept(s, int'(r), int'(c));
        end
        @(negedge clock); #2;
        start = 1'b0;
        single = 1'($urandom);
        sel_row = 2'($urandom);
        sel_col = 2'($urandom);
    endtask

    task automatic wait_idle(int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clock); #1;
            if (m_phase == 0 && exp_q.size() == 0 && !done_pending) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_idle timeout act=busy exp=idle");
    endtask

    task automatic model_reset();
        exp_q.delete();
        done_pending = 1'b0;
        last_pix = '0;
        m_phase = 0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #2 resetn = 1'b1;
        check_val("reset_plot", int'(plot), 0);
        check_val("reset_x", int'(x), 0);

        // Full redraw of an empty board
        grid = '0;
        pulse_start(1'b0, 2'd0, 2'd0);
        check_val("full_size", acc_q.size(), 6084);
        check_val("full_first", int'(acc_q[0]), int'({8'd37, 7'd7, 3'b111}));
        check_val("full_last", int'(acc_q[$]), int'({8'd122, 7'd92, 3'b111}));
        wait_idle(8000);
        check_val("full_count", run_pix, 6084);
        check_val("full_first_x", first_x, 37);
        check_val("full_first_y", first_y, 7);

        // Single cell (1,2) holding X
        grid = '0;
        grid[2*(1*N+2) +: 2] = 2'd2;
        pulse_start(1'b1, 2'd1, 2'd2);
        check_val("single_size", acc_q.size(), 676);
        check_val("single_first", int'(acc_q[0]), int'({8'd97, 7'd37, 3'b101}));
        check_val("single_last", int'(acc_q[$]), int'({8'd122, 7'd62, 3'b101}));
        wait_idle(1000);
        check_val("single_count", run_pix, 676);

        // Mixed codes, full redraw in row-major order
        grid = '0;
        grid[2*(2*N+0) +: 2] = 2'd3;
        grid[2*(0*N+1) +: 2] = 2'd1;
        pulse_start(1'b0, 2'd0, 2'd0);
        check_val("cell01_first", int'(acc_q[676]), int'({8'd67, 7'd7, 3'b011}));
        check_val("cell20_first", int'(acc_q[6*676]), int'({8'd37, 7'd67, 3'b000}));
        wait_idle(8000);

        // Out-of-range single request
        pulse_start(1'b1, 2'd3, 2'd0);
        check_val("oob_size", acc_q.size(), 0);
        wait_idle(20);
        check_val("oob_count", run_pix, 0);
        pulse_start(1'b1, 2'd0, 2'd3);
        wait_idle(20);

        // Grid flip and re-start while drawing
        grid = 18'($urandom);
        pulse_start(1'b0, 2'd0, 2'd0);
        repeat (500) @(negedge clock);
        #2 grid = ~grid;
        pulse_start(1'b0, 2'd1, 2'd1);
        pulse_start(1'b1, 2'd2, 2'd2);
        wait_idle(8000);
        check_val("flip_count", run_pix, 6084);

        // Start during the done cycle is ignored
        pulse_start(1'b1, 2'd0, 2'd0);
        for (int i = 0; i < 1000 && m_phase != 2; i++) begin
            @(negedge clock); #1;
        end
        check_val("done_phase_reached", m_phase, 2);
        #1 start = 1'b1; single = 1'b1; sel_row = 2'd1; sel_col = 2'd1;
        run_pix = 0;
        @(negedge clock); #2 start = 1'b0;
        repeat (5) @(negedge clock);
        check_val("done_start_ignored", run_pix, 0);

        // Reset in the middle of a full redraw
        grid = 18'($urandom);
        pulse_start(1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 200 && run_pix < 100; i++) begin
            @(negedge clock); #1;
        end
        #2 resetn = 1'b0;
        #1;
        check_val("mid_reset_plot", int'(plot), 0);
        check_val("mid_reset_done", int'(done), 0);
        check_val("mid_reset_busy", int'(busy), 0);
        model_reset();
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
        pulse_start(1'b0, 2'd0, 2'd0);
        wait_idle(8000);
        check_val("post_reset_first_x", first_x, 37);
        check_val("post_reset_first_y", first_y, 7);
        check_val("post_reset_count", run_pix, 6084);

        // Randomised requests, mostly single cells, grid churned after each start
        for (int k = 0; k < 10; k++) begin
            grid = 18'($urandom);
            pulse_start(($urandom % 4) != 0, 2'($urandom % 4), 2'($urandom % 4));
            grid = 18'($urandom);
            wait_idle(8000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog act=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
